// File: rtl/cp0_intr_unit.sv
// cp0_intr_unit: coprocessor-0 exception/interrupt unit for the pipelined core.
// Holds SR, Cause, EPC and PRId. Decides between a hardware interrupt and a
// synchronous exception from the M stage, records the victim PC and raises a
// combinational request that flushes the pipeline to the handler.
`timescale 1ns/1ps
module cp0_intr_unit #(
    parameter logic [31:0] PRID_VAL     = 32'h0000_4D49,
    parameter int          EPC_MASK_LOW = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] PC,
    input  logic        BD,
    input  logic [4:0]  ExcCode,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPC_out,
    output logic [31:0] DOut
);

    // Coprocessor-0 register numbers as seen by mfc0/mtc0.
    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    // Clears the low EPC_MASK_LOW bits so EPC always holds an aligned address.
    localparam logic [31:0] EPC_MASK = ~((32'd1 << EPC_MASK_LOW) - 32'd1);

    // Status register fields (all other SR bits read as zero).
    logic [5:0]  sr_im_q,     sr_im_d;
    logic        sr_exl_q,    sr_exl_d;
    logic        sr_ie_q,     sr_ie_d;

    // Cause register fields (all other Cause bits read as zero).
    logic        cause_bd_q,  cause_bd_d;
    logic [5:0]  cause_ip_q,  cause_ip_d;
    logic [4:0]  cause_exc_q, cause_exc_d;

    // Exception program counter.
    logic [31:0] epc_q,       epc_d;

    // Entry decision.
    logic        int_hit;
    logic        exc_hit;
    logic        entry;

    // Architectural views of SR and Cause for reads.
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    // Decide whether to enter the handler this cycle; EXL masks everything.
    always_comb begin
        int_hit = (|(HWInt & sr_im_q)) & sr_ie_q & ~sr_exl_q;
        exc_hit = (ExcCode != 5'd0) & ~sr_exl_q;
        entry   = int_hit | exc_hit;
    end

    assign IntReq  = entry;
    assign EPC_out = epc_q;

    // Next-state selection: entry beats eret, eret beats (and follows) mtc0.
    always_comb begin
        // NOTE: every _d gets a default from its _q first, so no path through
        // this block leaves a variable unassigned and no latch is inferred.
        sr_im_d     = sr_im_q;
        sr_exl_d    = sr_exl_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;
        // Pending lines are tracked every cycle regardless of the mask.
        cause_ip_d  = HWInt;

        if (entry) begin
            // mtc0 and eret in the same cycle are dropped with the flushed instruction.
            sr_exl_d    = 1'b1;
            cause_bd_d  = BD;
            cause_exc_d = int_hit ? 5'd0 : ExcCode;
            epc_d       = (BD ? (PC - 32'd4) : PC) & EPC_MASK;
        end else begin
            if (WE) begin
                case (A2)
                    REG_SR: begin
                        sr_im_d  = DIn[15:10];
                        sr_exl_d = DIn[1];
                        sr_ie_d  = DIn[0];
                    end
                    REG_EPC: epc_d = DIn & EPC_MASK;
                    default: ; // Cause, PRId and unmapped numbers are not writable
                endcase
            end
            // eret is applied after a same-cycle SR write so EXL always ends up clear.
            if (EXLClr) begin
                sr_exl_d = 1'b0;
            end
        end
    end

    // State register with synchronous, active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            sr_im_q     <= 6'd0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= 6'd0;
            cause_exc_q <= 5'd0;
            epc_q       <= 32'd0;
        end else begin
            sr_im_q     <= sr_im_d;
            sr_exl_q    <= sr_exl_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
        end
    end

    // Assemble the 32-bit register images from their fields.
    always_comb begin
        sr_word           = 32'd0;
        sr_word[15:10]    = sr_im_q;
        sr_word[1]        = sr_exl_q;
        sr_word[0]        = sr_ie_q;

        cause_word        = 32'd0;
        cause_word[31]    = cause_bd_q;
        cause_word[15:10] = cause_ip_q;
        cause_word[6:2]   = cause_exc_q;
    end

    // mfc0 read mux over current register values; no same-cycle write bypass.
    always_comb begin
        DOut = 32'd0;
        case (A1)
            REG_SR:    DOut = sr_word;
            REG_CAUSE: DOut = cause_word;
            REG_EPC:   DOut = epc_q;
            REG_PRID:  DOut = PRID_VAL;
            default:   DOut = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_intr_unit.sv
// tb_cp0_intr_unit: directed scenarios followed by a random run, every cycle
// checked against a word-level reference model of the CP0 register rules.
`timescale 1ns/1ps
module tb_cp0_intr_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] PC;
    logic        BD;
    logic [4:0]  ExcCode;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        IntReq;
    logic [31:0] EPC_out;
    logic [31:0] DOut;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state: whole register words.
    logic [31:0] m_sr;
    logic [31:0] m_cause;
    logic [31:0] m_epc;

    cp0_intr_unit dut (
        .clk     (clk),
        .reset   (reset),
        .A1      (A1),
        .A2      (A2),
        .DIn     (DIn),
        .WE      (WE),
        .PC      (PC),
        .BD      (BD),
        .ExcCode (ExcCode),
        .HWInt   (HWInt),
        .EXLClr  (EXLClr),
        .IntReq  (IntReq),
        .EPC_out (EPC_out),
        .DOut    (DOut)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model: does the unit enter the handler with the current inputs?
    function automatic logic m_take_int();
        return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_take();
        return m_take_int() || ((ExcCode != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h0000_4D49;
            default: return 32'd0;
        endcase
    endfunction

    // Model: apply one clock edge using the inputs present at the edge.
    task automatic m_edge();
        logic [31:0] ip;
        logic [31:0] code;
        logic [31:0] victim;
        ip = {16'd0, HWInt, 10'd0};
        if (reset) begin
            m_sr = 0; m_cause = 0; m_epc = 0;
        end else if (m_take()) begin
            code    = m_take_int() ? 32'd0 : {27'd0, ExcCode};
            m_sr    = m_sr | 32'h2;
            m_cause = ({31'd0, BD} << 31) | ip | (code << 2);
            victim  = BD ? PC - 32'd4 : PC;
            m_epc   = victim & ~32'h3;
        end else begin
            m_cause = (m_cause & 32'h8000_007C) | ip;
            if (WE && A2 == 5'd12) m_sr  = DIn & 32'h0000_FC03;
            if (WE && A2 == 5'd14) m_epc = DIn & ~32'h3;
            if (EXLClr)            m_sr  = m_sr & ~32'h2;
        end
    endtask

    // One clock: check outputs mid-cycle against the model, then advance both.
    task automatic tick();
        @(negedge clk);
        check("intreq", {31'd0, IntReq}, {31'd0, m_take()});
        check("epc_out", EPC_out, m_epc);
        check("dout", DOut, m_read(A1));
        @(posedge clk);
        m_edge();
        #1;
    endtask

    // Direct mfc0 read compared against a literal from the scenario.
    task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
        A1 = a;
        #1;
        check(tag, DOut, exp);
    endtask

    task automatic idle_inputs();
        reset = 0; WE = 0; A2 = 0; DIn = 0; EXLClr = 0;
        ExcCode = 0; BD = 0; PC = 32'h0000_3000; A1 = 0;
    endtask

    initial begin
        m_sr = 0; m_cause = 0; m_epc = 0;
        idle_inputs();
        HWInt = 0;
        reset = 1;
        tick();
        tick();
        reset = 0;

        // Reset state.
        check("rst_intreq", {31'd0, IntReq}, 32'd0);
        check("rst_epc_out", EPC_out, 32'd0);
        peek("rst_sr", 5'd12, 32'd0);
        peek("rst_cause", 5'd13, 32'd0);

        // Timer interrupt with IM[2] and IE set.
        WE = 1; A2 = 5'd12; DIn = 32'h0000_0401;
        tick();
        WE = 0;
        HWInt = 6'b000001; PC = 32'h0000_3010; BD = 0;
        #1;
        check("t1_intreq", {31'd0, IntReq}, 32'd1);
        tick();
        check("t1_intreq_after", {31'd0, IntReq}, 32'd0);
        peek("t1_sr", 5'd12, 32'h0000_0403);
        peek("t1_cause", 5'd13, 32'h0000_0400);
        peek("t1_epc", 5'd14, 32'h0000_3010);

        // Overflow exception in a delay slot with interrupts disabled.
        HWInt = 0;
        WE = 1; A2 = 5'd12; DIn = 32'h0;
        tick();
        WE = 0;
        ExcCode = 5'd12; PC = 32'h0000_3024; BD = 1;
        #1;
        check("t2_intreq", {31'd0, IntReq}, 32'd1);
        tick();
        ExcCode = 0; BD = 0;
        peek("t2_epc", 5'd14, 32'h0000_3020);
        peek("t2_cause", 5'd13, 32'h8000_0030);
        peek("t2_sr", 5'd12, 32'h0000_0002);

        // Interrupt and exception together: interrupt wins.
        WE = 1; A2 = 5'd12; DIn = 32'h0000_0401;
        tick();
        WE = 0;
        HWInt = 6'b000001; ExcCode = 5'd4; PC = 32'h0000_3040;
        #1;
        check("t3_intreq", {31'd0, IntReq}, 32'd1);
        tick();
        ExcCode = 0;
        peek("t3_cause", 5'd13, 32'h0000_0400);

        // Held IRQ while EXL=1 is suppressed, then fires right after eret.
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t4_suppressed", {31'd0, IntReq}, 32'd0);
            peek("t4_ip", 5'd13, 32'h0000_0400);
            tick();
        end
        EXLClr = 1;
        #1;
        check("t4_eret_cycle", {31'd0, IntReq}, 32'd0);
        tick();
        EXLClr = 0;
        #1;
        check("t4_refire", {31'd0, IntReq}, 32'd1);
        tick();

        // Writes to Cause and PRId are ignored; PRId and unmapped reads.
        WE = 1; A2 = 5'd13; DIn = 32'hFFFF_FFFF;
        tick();
        A2 = 5'd15;
        tick();
        WE = 0;
        peek("t5_cause", 5'd13, 32'h0000_0400);
        peek("t5_prid", 5'd15, 32'h0000_4D49);
        peek("t5_unmapped", 5'd7, 32'd0);

        // mtc0 EPC loses to a same-cycle entry; then reset mid-handler.
        EXLClr = 1;
        tick();
        EXLClr = 0;
        WE = 1; A2 = 5'd14; DIn = 32'h0000_3003; PC = 32'h0000_3050; BD = 0;
        #1;
        check("t6_intreq", {31'd0, IntReq}, 32'd1);
        tick();
        WE = 0;
        peek("t6_epc", 5'd14, 32'h0000_3050);
        reset = 1;
        tick();
        reset = 0;
        peek("t6_sr", 5'd12, 32'd0);
        peek("t6_cause", 5'd13, 32'd0);
        peek("t6_epc_rst", 5'd14, 32'd0);
        check("t6_epc_out", EPC_out, 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            reset   = ($urandom_range(0, 39) == 0);
            WE      = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 4))
                0:       A2 = 5'd12;
                1:       A2 = 5'd13;
                2:       A2 = 5'd14;
                3:       A2 = 5'd15;
                default: A2 = 5'($urandom_range(0, 31));
            endcase
            DIn     = $urandom;
            EXLClr  = ($urandom_range(0, 5) == 0);
            ExcCode = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            HWInt   = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
            BD      = 1'($urandom);
            PC      = $urandom;
            A1      = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                  : 5'($urandom_range(12, 15));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
